// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Size encodings, FSM state encoding, byte-lane mask, store-data lane
// replication, load extract/extend and misalignment detection.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte enables for a store; halves and words are forced aligned here.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Place right-justified store data on every lane it could target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] a, input logic uns);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Misaligned half/word, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic e;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = a[0];
      SZ_WORD: e = (a != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// DEPTH x DATA_W synchronous RAM, four byte-lane write enables,
// registered read that only updates when a read is requested.
// The array is deliberately not reset.
module dmem_bank_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [3:0]        i_be,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane writes and read-enabled registered read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_be[l]) r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
    end
    if (i_rd) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit between the MEM stage and the data RAM.
// Byte/half/word accesses, signed/unsigned load extension, req/ready/valid
// handshake with WAIT_CYCLES stall cycles before each access.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned or reserved-size accesses
// are suppressed and reported on m_err; otherwise accesses are forced
// aligned and m_err stays 0.
//
// state  | meaning
// IDLE   | ready, waiting for m_req
// WAIT   | counting down stall cycles
// ACCESS | RAM written (store) or read (load) on the exiting edge
// RESP   | m_valid high for one cycle with m_out/m_err
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  output logic              m_ready,
  input  logic              m_write,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [ADDR_W-1:0] m_addrs,
  input  logic [DATA_W-1:0] m_in,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_out,
  output logic              m_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [IDX_W+1:0]    r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                r_write;
  logic                r_err;
  logic [DATA_W-1:0]   r_out;

  logic                w_accept;
  logic                w_misalign;
  logic [3:0]          w_be;
  logic                w_rd;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_ext;
  logic                w_unused;

  // Upper address bits alias; they are intentionally dropped.
  assign w_unused = &{1'b0, m_addrs[ADDR_W-1:IDX_W+2]};

  assign w_accept = (r_state == ST_IDLE) && m_req;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(r_size, r_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_be = (r_state == ST_ACCESS && r_write && !w_misalign) ? lane_mask(r_size, r_addr[1:0])
                                                                 : 4'b0000;
  assign w_rd = (r_state == ST_ACCESS) && !r_write;

  dmem_bank_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_be    (w_be),
    .i_wdata (store_lanes(r_size, r_wdata)),
    .i_rd    (w_rd),
    .o_rdata (w_rdata)
  );

  // Stores and flagged accesses return zero data.
  assign w_ext = (r_write || r_err) ? '0 : load_extract(w_rdata, r_size, r_addr[1:0], r_uns);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (m_req) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (r_cnt == 4'd0) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request capture, stall counter and held response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= m_addrs[IDX_W+1:0];
        r_wdata <= m_in;
        r_size  <= m_size;
        r_uns   <= m_unsigned;
        r_write <= m_write;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_ACCESS) r_err <= w_misalign;
      if (r_state == ST_RESP)   r_out <= w_ext;
    end
  end

  // m_out shows the fresh result during RESP and holds it afterwards.
  assign m_out   = (r_state == ST_RESP) ? w_ext : r_out;
  assign m_err   = r_err;
  assign m_valid = (r_state == ST_RESP);
  assign m_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two instances, WAIT_CYCLES=0 and 3.
// Honours DMEM_ALIGN_CHECK_EN when defined for the build.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        write [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] addr  [2];
  logic [31:0] din   [2];
  logic        ready [2];
  logic        valid [2];
  logic [31:0] dout  [2];
  logic        err   [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   lat [2] = '{2, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .m_req(req[0]), .m_ready(ready[0]), .m_write(write[0]),
    .m_size(size[0]), .m_unsigned(uns[0]), .m_addrs(addr[0]), .m_in(din[0]),
    .m_valid(valid[0]), .m_out(dout[0]), .m_err(err[0]));

  dmem_lsu #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .m_req(req[1]), .m_ready(ready[1]), .m_write(write[1]),
    .m_size(size[1]), .m_unsigned(uns[1]), .m_addrs(addr[1]), .m_in(din[1]),
    .m_valid(valid[1]), .m_out(dout[1]), .m_err(err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: pop and compare on every response strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i]) begin
          if (qsize(i) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid dut%0d: got m_valid=1 expected no response", i);
          end else begin
            mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("m_out dut%0d", i), dout[i], mon_e.data);
            chk($sformatf("m_err dut%0d", i), {31'd0, err[i]}, {31'd0, mon_e.err});
            chk($sformatf("latency dut%0d", i), cyc + 1 - mon_e.acc, lat[i]);
            chk($sformatf("ready_in_resp dut%0d", i), {31'd0, ready[i]}, 32'd0);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input int i, input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input logic hold,
                       output int acc);
    int   n;
    exp_t e;
    write[i] = wr; size[i] = sz; uns[i] = u; addr[i] = a; din[i] = d; req[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (!ready[i]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req[i] = 1'b0;
    end else begin
      acc = cyc + 1;
      e.data = ed; e.err = ee; e.acc = acc;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      @(negedge clk);
      chk("ready_low_after_accept", {31'd0, ready[i]}, 32'd0);
      if (!hold) req[i] = 1'b0;
    end
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while ((qsize(i) != 0 || !ready[i]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qsize(i) != 0) chk("response_timeout", qsize(i), 32'd0);
  endtask

  logic [31:0] ex_err_out;
  logic        ex_err;
  logic [31:0] ex_w40;

  initial begin
    int a0, a1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; write[i] = 0; size[i] = 2'b10; uns[i] = 0; addr[i] = 0; din[i] = 0;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    ex_err = 1'b1; ex_err_out = 32'h0;        ex_w40 = 32'hA5A5A5A5;
`else
    ex_err = 1'b0; ex_err_out = 32'h0000ABCD; ex_w40 = 32'h13572468;
`endif
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", {31'd0, ready[i]}, 32'd1);
      chk("reset_valid", {31'd0, valid[i]}, 32'd0);
      chk("reset_out", dout[i], 32'd0);
      chk("reset_err", {31'd0, err[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store/load, back-to-back with m_req held
    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, a0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, a1);
    chk("throughput_w0", a1 - a0, 32'd3);
    wait_done(0);

    // 2: byte store into a word, signed/unsigned byte loads, alias
    issue(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 0, a0);
    issue(0, 1, 2'b00, 0, 32'h13, 32'h12345680, 32'h0, 0, 0, a0);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0, a0);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 0, a0);
    issue(0, 0, 2'b10, 0, 32'h1010, 32'h0, 32'h80223344, 0, 0, a0);
    wait_done(0);
    @(negedge clk);
    chk("m_out_hold", dout[0], 32'h80223344);

    // 3: half store into upper lanes, half/byte loads
    issue(0, 1, 2'b10, 0, 32'h20, 32'h55667788, 32'h0, 0, 0, a0);
    issue(0, 1, 2'b01, 0, 32'h22, 32'h9999ABCD, 32'h0, 0, 0, a0);
    issue(0, 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFABCD, 0, 0, a0);
    issue(0, 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000ABCD, 0, 0, a0);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hABCD7788, 0, 0, a0);
    issue(0, 0, 2'b00, 1, 32'h20, 32'h0, 32'h00000088, 0, 0, a0);
    issue(0, 0, 2'b01, 1, 32'h23, 32'h0, ex_err_out, ex_err, 0, a0);
    wait_done(0);

    // 4: wait states, request held during busy period
    issue(1, 1, 2'b10, 0, 32'h30, 32'h01020304, 32'h0, 0, 1, a0);
    issue(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h01020304, 0, 0, a1);
    chk("throughput_w3", a1 - a0, 32'd6);
    wait_done(1);

    // 5: reset during WAIT of a store drops it
    issue(1, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, a0);
    wait_done(1);
    write[1] = 1; size[1] = 2'b10; addr[1] = 32'h40; din[1] = 32'h0BADBEEF; req[1] = 1;
    @(negedge clk);
    req[1] = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_ready", {31'd0, ready[1]}, 32'd1);
    chk("abort_valid", {31'd0, valid[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0, a0);
    wait_done(1);

    // 6: misaligned word store
    issue(0, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 0, a0);
    issue(0, 1, 2'b10, 0, 32'h42, 32'h13572468, 32'h0, ex_err, 0, a0);
    issue(0, 0, 2'b10, 0, 32'h40, 32'h0, ex_w40, 0, 0, a0);
    wait_done(0);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
